// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;
  typedef enum logic [2:0] {LEN, DATA, ACK, NAK, DONE, ERR} loader_state_t;
  localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;
  localparam logic [7:0] NAK_BYTE_DEF = 8'h55;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/byte_to_word.sv
// Little-endian byte-to-word assembler. word/word_valid are combinational so the
// consumer can register the completed word in the same cycle as its last byte.
module byte_to_word
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);
  localparam int BW = $clog2(WORD_BYTES);
  localparam int SW = 8 * (WORD_BYTES - 1);

  logic [BW-1:0] bidx;
  // Only the bytes still waiting for the final one need storage.
  logic [SW-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      bidx <= '0;
      sr   <= '0;
    end else if (in_valid) begin
      bidx <= bidx + BW'(1);
      sr   <= {in_data, sr[SW-1:8]};
    end
  end

  assign word       = {in_data, sr};
  assign word_valid = in_valid && (bidx == BW'(WORD_BYTES - 1));
endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed UART byte stream, writes it into the
// instruction RAM word by word, then reports ACK/NAK on TX.
module imem_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          DEPTH    = 1024,
  parameter logic [7:0]  ACK_BYTE = ACK_BYTE_DEF,
  parameter logic [7:0]  NAK_BYTE = NAK_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              loading,
  output logic              done,
  output logic              err
);
  loader_state_t   state, state_nxt;
  logic [ADDR_W:0] wcnt, wcnt_inc;
  logic [31:0]     n, word;
  logic            word_valid, accept;

  assign accept = rx_valid && (state == LEN || state == DATA);

  byte_to_word u_b2w (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (accept),
    .in_data    (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // One spare bit so a full-depth count compares without wrapping.
  assign wcnt_inc = wcnt + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    state_nxt = state;
    case (state)
      LEN: if (word_valid) begin
        if (word == '0)               state_nxt = ACK;
        else if (word > 32'(DEPTH))   state_nxt = NAK;
        else                          state_nxt = DATA;
      end
      DATA:    if (word_valid && 32'(wcnt_inc) == n) state_nxt = ACK;
      ACK:     if (tx_valid && tx_ready) state_nxt = DONE;
      NAK:     if (tx_valid && tx_ready) state_nxt = ERR;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LEN;
      wcnt     <= '0;
      n        <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      loading  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      we    <= 1'b0;
      if (state == LEN && word_valid) begin
        n    <= word;
        wcnt <= '0;
      end
      if (state == DATA && word_valid) begin
        we    <= 1'b1;
        waddr <= wcnt[ADDR_W-1:0];
        wdata <= word;
        wcnt  <= wcnt_inc;
      end
      // Status outputs follow the state being entered so they line up with it.
      tx_valid <= (state_nxt == ACK) || (state_nxt == NAK);
      tx_data  <= (state_nxt == ACK) ? ACK_BYTE :
                  (state_nxt == NAK) ? NAK_BYTE : 8'h00;
      loading  <= (state_nxt != DONE);
      done     <= (state_nxt == DONE);
      err      <= (state_nxt == ERR);
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, random streams, reset corners.
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst, rx_valid, tx_ready;
  logic [7:0]        rx_data, tx_data;
  logic              tx_valid, we, loading, done, err;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  int errors = 0;
  int checks = 0;
  int wr_total = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ACK_BYTE(8'hAA), .NAK_BYTE(8'h55)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .we(we), .waddr(waddr), .wdata(wdata),
    .loading(loading), .done(done), .err(err)
  );

  always @(negedge clk) if (we === 1'b1) wr_total++;

  typedef struct {
    logic [31:0] n, w0, w1, mix;
    int          extra, gap_max, rdy_dly;
    logic [7:0]  exp_tx;
    bit          exp_err;
    int          exp_wr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input vec_t v, input int k);
    if (k == 0) return v.w0;
    if (k == 1) return v.w1;
    return 32'(k) ^ v.mix;
  endfunction

  // Entered and left at a negedge; optionally offers a byte during the reset cycle.
  task automatic do_reset(input bit byte_during);
    rst = 1'b1; tx_ready = 1'b0;
    rx_valid = byte_during; rx_data = 8'h77;
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_loading", loading, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  // Reference: byte i of the stream completes data word (i-4)/4 iff it is the
  // 4th byte of a word within the first min(N,0 if N>DEPTH) words.
  task automatic run_vector(input vec_t v);
    int nw, total, j, k, base;
    logic [31:0] w;
    logic [7:0] b;
    bit exp_we;
    base  = wr_total;
    nw    = (v.n > DEPTH) ? 0 : int'(v.n);
    total = 4 + 4 * nw + v.extra;
    for (int i = 0; i < total; i++) begin
      int g;
      g = (v.gap_max > 0) ? int'($urandom_range(v.gap_max, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        chk("we_idle", we, 0);
      end
      j = (i - 4) / 4;
      k = (i - 4) % 4;
      w = '0;
      if (i < 4) begin
        w = v.n; b = w[8*i +: 8];
      end else if (j < nw) begin
        w = word_of(v, j); b = w[8*k +: 8];
      end else begin
        b = 8'($urandom);
      end
      rx_valid = 1'b1; rx_data = b;
      @(negedge clk);
      rx_valid = 1'b0;
      exp_we = (i >= 4) && (j < nw) && (k == 3);
      chk("we", we, 32'(exp_we));
      if (exp_we) begin
        chk("waddr", waddr, 32'(j));
        chk("wdata", wdata, w);
      end
    end
    chk("tx_valid", tx_valid, 1);
    chk("tx_data", tx_data, v.exp_tx);
    chk("loading_pre", loading, 1);
    chk("done_pre", done, 0);
    repeat (v.rdy_dly) begin
      @(negedge clk);
      chk("tx_hold_valid", tx_valid, 1);
      chk("tx_hold_data", tx_data, v.exp_tx);
      chk("done_hold", done, 0);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("done", done, 32'(!v.exp_err));
    chk("err", err, 32'(v.exp_err));
    chk("loading", loading, 32'(v.exp_err));
    chk("tx_valid_after", tx_valid, 0);
    chk("writes", 32'(wr_total - base), 32'(v.exp_wr));
    // Bytes after completion are ignored.
    rx_valid = 1'b1; rx_data = 8'h3C;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("post_we", 32'(wr_total - base), 32'(v.exp_wr));
    chk("post_done", done, 32'(!v.exp_err));
    chk("post_err", err, 32'(v.exp_err));
  endtask

  vec_t vecs[6];
  vec_t rv;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    vecs[0] = '{32'd2, 32'h12345678, 32'hDEADBEEF, 32'h0, 0, 0, 0, 8'hAA, 1'b0, 2};
    vecs[1] = '{32'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 8'hAA, 1'b0, 0};
    vecs[2] = '{32'd1025, 32'h0, 32'h0, 32'h0, 5, 1, 0, 8'h55, 1'b1, 0};
    vecs[3] = '{32'd1024, 32'h0, 32'h1, 32'h0, 0, 0, 0, 8'hAA, 1'b0, 1024};
    vecs[4] = '{32'd1, 32'h0BADF00D, 32'h0, 32'h0, 0, 0, 10, 8'hAA, 1'b0, 1};
    vecs[5] = '{32'd3, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 4, 2, 3, 8'hAA, 1'b0, 3};
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      do_reset(1'b0);
      run_vector(vecs[v]);
    end

    // Random streams checked against the arithmetic reference.
    for (int r = 0; r < 6; r++) begin
      rv.n       = (r == 4) ? 32'hFFFF_FFFF :
                   (r == 5) ? 32'($urandom_range(5000, 1025)) : 32'($urandom_range(40, 0));
      rv.w0      = $urandom; rv.w1 = $urandom; rv.mix = $urandom;
      rv.extra   = int'($urandom_range(3, 0));
      rv.gap_max = int'($urandom_range(2, 0));
      rv.rdy_dly = int'($urandom_range(4, 0));
      rv.exp_err = (rv.n > DEPTH);
      rv.exp_tx  = rv.exp_err ? 8'h55 : 8'hAA;
      rv.exp_wr  = rv.exp_err ? 0 : int'(rv.n);
      do_reset(1'b0);
      run_vector(rv);
    end

    // Reset in the middle of the first data word of a 3-word load.
    begin
      int base;
      logic [31:0] cnt;
      do_reset(1'b0);
      base = wr_total;
      cnt  = 32'd3;
      for (int i = 0; i < 6; i++) begin
        rx_valid = 1'b1; rx_data = (i < 4) ? cnt[8*i +: 8] : 8'hEE;
        @(negedge clk);
      end
      rx_valid = 1'b0;
      do_reset(1'b1);
      @(negedge clk);
      chk("abort_we", 32'(wr_total - base), 0);
      rv = '{32'd1, 32'hCAFEF00D, 32'h0, 32'h0, 0, 0, 0, 8'hAA, 1'b0, 1};
      run_vector(rv);
    end

    // Reset while waiting for the TX handshake.
    begin
      logic [31:0] cnt;
      do_reset(1'b0);
      cnt = 32'd0;
      for (int i = 0; i < 4; i++) begin
        rx_valid = 1'b1; rx_data = cnt[8*i +: 8];
        @(negedge clk);
      end
      rx_valid = 1'b0;
      chk("hs_tx_valid", tx_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("hs_rst_tx_valid", tx_valid, 0);
      chk("hs_rst_done", done, 0);
      chk("hs_rst_loading", loading, 1);
      // tx_ready with no offer must not complete anything.
      tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      tx_ready = 1'b0;
      chk("hs_idle_done", done, 0);
      chk("hs_idle_tx_valid", tx_valid, 0);
      rv = '{32'd2, 32'h01020304, 32'hF0E0D0C0, 32'h0, 0, 1, 1, 8'hAA, 1'b0, 2};
      run_vector(rv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
